// File: rtl/timer_ctrl_master.sv
// timer_ctrl_master: Avalon-MM master for the 16-bit interval-timer slave.
// Converts high-level commands (LOAD, START, STOP, SNAP, POLL, CLEAR) taken
// on a valid/ready port into bus write/read sequences. Each command ends in
// a one-cycle response strobe.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   cmd_valid_i / cmd_ready_o    command handshake (ready only while idle)
//   cmd_op_i [2:0]               0=LOAD 1=START 2=STOP 3=SNAP 4=POLL 5=CLEAR
//   cmd_data_i [31:0]            period value for LOAD
//   rsp_valid_o                  one-cycle completion pulse
//   rsp_data_o [31:0]            SNAP snapshot / POLL {run,to} / else 0
//   rsp_err_o                    illegal opcode, qualifies rsp_valid_o
//   m_address_o, m_chipselect_o, m_write_n_o, m_writedata_o, m_readdata_i
//                                timer slave bus (all outputs registered)
//   irq_in_i                     timer irq level
//   irq_ack_o                    only with TIMER_CTRL_MASTER_IRQ_ACK_EN
//
// Optional feature macro: TIMER_CTRL_MASTER_IRQ_ACK_EN. When defined, an idle
// master with irq_in_i high and no command pending issues an internal CLEAR
// and pulses irq_ack_o instead of rsp_valid_o.
module timer_ctrl_master #(
  parameter bit          CTRL_CONT    = 1'b1,
  parameter bit          CTRL_ITO     = 1'b1,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [2:0]  cmd_op_i,
  input  logic [31:0] cmd_data_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_data_o,
  output logic        rsp_err_o,
  output logic [2:0]  m_address_o,
  output logic        m_chipselect_o,
  output logic        m_write_n_o,
  output logic [15:0] m_writedata_o,
  input  logic [15:0] m_readdata_i,
`ifdef TIMER_CTRL_MASTER_IRQ_ACK_EN
  output logic        irq_ack_o,
`endif
  input  logic        irq_in_i
);

  localparam logic [2:0] OpLoad  = 3'd0;
  localparam logic [2:0] OpStart = 3'd1;
  localparam logic [2:0] OpStop  = 3'd2;
  localparam logic [2:0] OpSnap  = 3'd3;
  localparam logic [2:0] OpPoll  = 3'd4;
  localparam logic [2:0] OpClear = 3'd5;

  typedef enum logic [2:0] {
    StIdle, StWr0, StWr1, StRdIssue, StRdWait, StDone
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] data_q, data_d;
  logic        err_q, err_d;
  logic        hi_phase_q, hi_phase_d;  // SNAP: second (high-half) read pending
  logic        intl_q, intl_d;          // internal irq-driven CLEAR in flight
  logic [1:0]  cnt_q, cnt_d;
  logic [15:0] lo_q, lo_d;
  logic [15:0] hi_q, hi_d;

  logic        cmd_ready_q, cmd_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_err_q, rsp_err_d;
  logic [2:0]  m_address_q, m_address_d;
  logic        m_cs_q, m_cs_d;
  logic        m_write_n_q, m_write_n_d;
  logic [15:0] m_wdata_q, m_wdata_d;

  logic        irq_req;

`ifdef TIMER_CTRL_MASTER_IRQ_ACK_EN
  logic        irq_ack_q, irq_ack_d;
  assign irq_req = irq_in_i;
`else
  logic        unused_irq;
  assign unused_irq = irq_in_i;
  assign irq_req    = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    data_d      = data_q;
    err_d       = err_q;
    hi_phase_d  = hi_phase_q;
    intl_d      = intl_q;
    cnt_d       = cnt_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_data_d  = rsp_data_q;
    m_cs_d      = 1'b0;
    m_write_n_d = 1'b1;
    m_address_d = m_address_q;
    m_wdata_d   = 16'h0;
`ifdef TIMER_CTRL_MASTER_IRQ_ACK_EN
    irq_ack_d   = 1'b0;
`endif

    unique case (state_q)
      StIdle: begin
        // cmd_ready_q gates acceptance so nothing starts in the reset-release cycle
        if (cmd_ready_q && cmd_valid_i) begin
          op_d       = cmd_op_i;
          data_d     = cmd_data_i;
          err_d      = 1'b0;
          hi_phase_d = 1'b0;
          intl_d     = 1'b0;
          case (cmd_op_i)
            OpPoll:                                   state_d = StRdIssue;
            OpLoad, OpStart, OpStop, OpSnap, OpClear: state_d = StWr0;
            default: begin
              err_d   = 1'b1;
              state_d = StDone;
            end
          endcase
        end else if (cmd_ready_q && irq_req) begin
          op_d    = OpClear;
          err_d   = 1'b0;
          intl_d  = 1'b1;
          state_d = StWr0;
        end
      end
      StWr0: begin
        if (op_q == OpLoad)      state_d = StWr1;
        else if (op_q == OpSnap) state_d = StRdIssue;
        else                     state_d = StDone;
      end
      StWr1: state_d = StDone;
      StRdIssue: begin
        cnt_d   = 2'(READ_LATENCY);
        state_d = StRdWait;
      end
      StRdWait: begin
        if (cnt_q == 2'd1) begin
          if (op_q == OpSnap && !hi_phase_q) begin
            lo_d       = m_readdata_i;
            hi_phase_d = 1'b1;
            state_d    = StRdIssue;
          end else begin
            if (op_q == OpSnap) hi_d = m_readdata_i;
            else                lo_d = m_readdata_i;
            state_d = StDone;
          end
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
        if (intl_q) begin
`ifdef TIMER_CTRL_MASTER_IRQ_ACK_EN
          irq_ack_d = 1'b1;
`endif
        end else begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = err_q;
          if (op_q == OpSnap)      rsp_data_d = {hi_q, lo_q};
          else if (op_q == OpPoll) rsp_data_d = {30'b0, lo_q[1:0]};
          else                     rsp_data_d = 32'h0;
        end
      end
      default: state_d = StIdle;
    endcase

    // Bus outputs are registered from the next state so each access lines up
    // with the state that owns it.
    unique case (state_d)
      StWr0: begin
        m_cs_d      = 1'b1;
        m_write_n_d = 1'b0;
        case (op_d)
          OpLoad: begin
            m_address_d = 3'd2;
            m_wdata_d   = data_d[15:0];
          end
          OpStart: begin
            m_address_d = 3'd1;
            m_wdata_d   = {12'b0, 1'b0, 1'b1, CTRL_CONT, CTRL_ITO};
          end
          OpStop: begin
            m_address_d = 3'd1;
            m_wdata_d   = {12'b0, 1'b1, 1'b0, 1'b0, CTRL_ITO};
          end
          OpSnap:  m_address_d = 3'd4;
          default: m_address_d = 3'd0;
        endcase
      end
      StWr1: begin
        m_cs_d      = 1'b1;
        m_write_n_d = 1'b0;
        m_address_d = 3'd3;
        m_wdata_d   = data_d[31:16];
      end
      StRdIssue: begin
        m_cs_d = 1'b1;
        if (op_d == OpPoll)  m_address_d = 3'd0;
        else if (hi_phase_d) m_address_d = 3'd5;
        else                 m_address_d = 3'd4;
      end
      default: ;
    endcase

    cmd_ready_d = (state_d == StIdle);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      op_q        <= 3'd0;
      data_q      <= 32'h0;
      err_q       <= 1'b0;
      hi_phase_q  <= 1'b0;
      intl_q      <= 1'b0;
      cnt_q       <= 2'd0;
      lo_q        <= 16'h0;
      hi_q        <= 16'h0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'h0;
      rsp_err_q   <= 1'b0;
      m_address_q <= 3'd0;
      m_cs_q      <= 1'b0;
      m_write_n_q <= 1'b1;
      m_wdata_q   <= 16'h0;
`ifdef TIMER_CTRL_MASTER_IRQ_ACK_EN
      irq_ack_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      data_q      <= data_d;
      err_q       <= err_d;
      hi_phase_q  <= hi_phase_d;
      intl_q      <= intl_d;
      cnt_q       <= cnt_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      m_address_q <= m_address_d;
      m_cs_q      <= m_cs_d;
      m_write_n_q <= m_write_n_d;
      m_wdata_q   <= m_wdata_d;
`ifdef TIMER_CTRL_MASTER_IRQ_ACK_EN
      irq_ack_q   <= irq_ack_d;
`endif
    end
  end

  assign cmd_ready_o    = cmd_ready_q;
  assign rsp_valid_o    = rsp_valid_q;
  assign rsp_data_o     = rsp_data_q;
  assign rsp_err_o      = rsp_err_q;
  assign m_address_o    = m_address_q;
  assign m_chipselect_o = m_cs_q;
  assign m_write_n_o    = m_write_n_q;
  assign m_writedata_o  = m_wdata_q;
`ifdef TIMER_CTRL_MASTER_IRQ_ACK_EN
  assign irq_ack_o      = irq_ack_q;
`endif

endmodule
